// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for the 16-bit five-stage core. It watches the ID and EX
//   stages and the data-memory handshake. It then decides each cycle whether
//   the PC and the IF/ID register may advance. It also decides whether IF/ID
//   or ID/EX must be loaded with a bubble, and whether the back half of the
//   pipe must hold.
//
//   Events are handled in this priority order:
//   reset > mem_wait > taken branch > load-use > HLT.
//   A small RUN/FLUSH/HALT state machine tracks events that span more than
//   one cycle.
//
//   Optional feature macro: HAZARD_PERF_EN
//     When defined, the module gains the CNT_W parameter and the
//     stall_count/flush_count outputs. Both counters saturate at all-ones.
//
// Parameters
//   FLUSH_CYCLES  number of cycles op_if_id_flush stays high after a taken
//                 branch (1..15)
//   REG_W         register-index width
//   CNT_W         perf counter width (HAZARD_PERF_EN only)
//
// Ports
//   clock           core clock, rising edge
//   reset           asynchronous, active-low
//   id_rs, id_rt    source registers of the instruction in ID
//   id_uses_rs/rt   ID instruction actually reads that source
//   id_halt         ID instruction is HLT
//   ex_mem_read     EX instruction is a load
//   ex_reg_write    EX instruction writes a register
//   ex_rd           EX destination register
//   ex_branch_taken EX resolved a taken branch/jump this cycle
//   mem_wait        data memory not ready, freeze the whole pipe
//   restart         one-cycle pulse that leaves HALT
//   op_pc_write     PC may update
//   op_if_id_write  IF/ID may load
//   op_if_id_flush  IF/ID loads a NOP
//   op_id_ex_flush  ID/EX loads a bubble
//   op_pipe_hold    EX/MEM and MEM/WB hold their contents
//   halted          core is in HALT
//   stall_count     load-use + mem_wait cycles (HAZARD_PERF_EN only)
//   flush_count     cycles with op_if_id_flush high (HAZARD_PERF_EN only)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned REG_W        = 3
`ifdef HAZARD_PERF_EN
  ,
  parameter int unsigned CNT_W        = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_wait,
  input  logic             restart,
  output logic             op_pc_write,
  output logic             op_if_id_write,
  output logic             op_if_id_flush,
  output logic             op_id_ex_flush,
  output logic             op_pipe_hold,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
`endif
  output logic             halted
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Value loaded into the flush counter when a taken branch is seen. The branch
  // cycle itself is the first flush cycle, so the counter covers the remainder.
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic load_use;
  logic branch_ev;
  logic load_use_ev;
  logic halt_ev;

  // Event qualification. A raw load-use match is only acted upon in RUN, and
  // only when neither a memory wait nor a taken branch outranks it. A HLT in ID
  // is honoured only when nothing above it fires. This lets a branch in EX
  // squash the HLT, and lets a load-use stall delay the HLT by a cycle.
  always_comb begin
    load_use    = ex_mem_read & ex_reg_write &
                  ((id_uses_rs & (id_rs == ex_rd)) |
                   (id_uses_rt & (id_rt == ex_rd)));
    branch_ev   = ex_branch_taken & ~mem_wait & (state_q != ST_HALT);
    load_use_ev = (state_q == ST_RUN) & ~mem_wait & ~ex_branch_taken & load_use;
    halt_ev     = (state_q == ST_RUN) & ~mem_wait & ~ex_branch_taken & ~load_use &
                  id_halt;
  end

  // State and flush-counter register. An asynchronous reset drops straight
  // back to RUN from any state, including mid-flush and mid-halt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. mem_wait freezes everything, because the stalled pipe
  // keeps the inputs stable. The same events are then re-evaluated once the
  // memory is ready. A taken branch seen while already in FLUSH reloads the
  // counter, so the newest redirect always gets its full flush window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_wait) begin
      if (branch_ev) begin
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_RELOAD;
        end else begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      end else begin
        case (state_q)
          ST_RUN: begin
            if (halt_ev) begin
              state_d = ST_HALT;
            end
          end
          ST_FLUSH: begin
            if (cnt_q <= 4'd1) begin
              state_d = ST_RUN;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
          ST_HALT: begin
            if (restart) begin
              state_d = ST_RUN;
            end
          end
          default: begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end
        endcase
      end
    end
  end

  // Output decode. Every control is combinational, so it acts in the same
  // cycle as the hazard that causes it. While reset is low, the front end is
  // parked with both flushes asserted, so the pipe fills with NOPs and bubbles.
  always_comb begin
    op_pc_write    = 1'b1;
    op_if_id_write = 1'b1;
    op_if_id_flush = 1'b0;
    op_id_ex_flush = 1'b0;
    op_pipe_hold   = 1'b0;
    halted         = (state_q == ST_HALT);
    if (!reset) begin
      op_pc_write    = 1'b0;
      op_if_id_write = 1'b0;
      op_if_id_flush = 1'b1;
      op_id_ex_flush = 1'b1;
      halted         = 1'b0;
    end else if (mem_wait) begin
      op_pc_write    = 1'b0;
      op_if_id_write = 1'b0;
      op_pipe_hold   = 1'b1;
    end else if (branch_ev) begin
      op_if_id_flush = 1'b1;
      op_id_ex_flush = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_use_ev || halt_ev) begin
            op_pc_write    = 1'b0;
            op_if_id_write = 1'b0;
            op_id_ex_flush = 1'b1;
          end
        end
        ST_FLUSH: begin
          op_if_id_flush = 1'b1;
        end
        ST_HALT: begin
          op_pc_write    = 1'b0;
          op_if_id_write = 1'b0;
          op_id_ex_flush = 1'b1;
        end
        default: begin
          op_pc_write = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating performance counters. A stall is either a memory-wait cycle or
  // a load-use cycle that was actually taken. Load-use matches that are
  // outranked by a branch, or that occur outside RUN, are not counted. A
  // flush cycle is any cycle in which IF/ID is loaded with a NOP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((mem_wait || load_use_ev) && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (op_if_id_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. Two instances share the same inputs:
//   dut uses FLUSH_CYCLES=3, and dut1 uses FLUSH_CYCLES=1.
//
//   Inputs are driven just after the falling edge. The combinational controls
//   are sampled 1ns later, well away from the rising edge.
//
//   The expected control vectors are packed in this order:
//   {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, halted}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_halt;
  logic       ex_mem_read, ex_reg_write, ex_branch_taken, mem_wait, restart;

  logic op_pc_write, op_if_id_write, op_if_id_flush, op_id_ex_flush, op_pipe_hold, halted;
  logic f1_pc_write, f1_if_id_write, f1_if_id_flush, f1_id_ex_flush, f1_pipe_hold, f1_halted;
`ifdef HAZARD_PERF_EN
  logic [3:0] stall_count, flush_count, f1_stall_count, f1_flush_count;
`endif

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [5:0] RUNV   = 6'b110000;
  localparam logic [5:0] RSTV   = 6'b001100;
  localparam logic [5:0] STALLV = 6'b000100;
  localparam logic [5:0] BRV    = 6'b111100;
  localparam logic [5:0] FLV    = 6'b111000;
  localparam logic [5:0] HOLDV  = 6'b000010;
  localparam logic [5:0] HALTV  = 6'b000101;
  localparam logic [5:0] HHOLDV = 6'b000011;

  // Hazard-field patterns: {ex_mem_read, ex_reg_write, id_uses_rs, id_uses_rt}.
  localparam logic [3:0] NOHZ = 4'b0000;
  localparam logic [3:0] LU   = 4'b1110;

  always #5 clock = ~clock;

  hazard_ctrl #(
    .FLUSH_CYCLES(3),
    .REG_W(3)
`ifdef HAZARD_PERF_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .restart(restart),
    .op_pc_write(op_pc_write), .op_if_id_write(op_if_id_write),
    .op_if_id_flush(op_if_id_flush), .op_id_ex_flush(op_id_ex_flush),
    .op_pipe_hold(op_pipe_hold),
`ifdef HAZARD_PERF_EN
    .stall_count(stall_count), .flush_count(flush_count),
`endif
    .halted(halted)
  );

  hazard_ctrl #(
    .FLUSH_CYCLES(1),
    .REG_W(3)
`ifdef HAZARD_PERF_EN
    ,
    .CNT_W(4)
`endif
  ) dut1 (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .restart(restart),
    .op_pc_write(f1_pc_write), .op_if_id_write(f1_if_id_write),
    .op_if_id_flush(f1_if_id_flush), .op_id_ex_flush(f1_id_ex_flush),
    .op_pipe_hold(f1_pipe_hold),
`ifdef HAZARD_PERF_EN
    .stall_count(f1_stall_count), .flush_count(f1_flush_count),
`endif
    .halted(f1_halted)
  );

  // Drive one cycle's worth of inputs just after the falling edge, then let
  // the combinational outputs settle.
  task automatic applyStimulus(input logic [3:0] hz, input logic [2:0] rs,
                               input logic [2:0] rt, input logic [2:0] rd,
                               input logic br, input logic hlt, input logic mw,
                               input logic rsr);
    @(negedge clock);
    {ex_mem_read, ex_reg_write, id_uses_rs, id_uses_rt} = hz;
    id_rs           = rs;
    id_rt           = rt;
    ex_rd           = rd;
    ex_branch_taken = br;
    id_halt         = hlt;
    mem_wait        = mw;
    restart         = rsr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expVec);
    logic [5:0] obs;
    obs = {op_pc_write, op_if_id_write, op_if_id_flush, op_id_ex_flush, op_pipe_hold, halted};
    assertCount++;
    assert (obs === expVec)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expVec);
    end
  endtask

  task automatic checkOutput1(input string tag, input logic [5:0] expVec);
    logic [5:0] obs;
    obs = {f1_pc_write, f1_if_id_write, f1_if_id_flush, f1_id_ex_flush, f1_pipe_hold, f1_halted};
    assertCount++;
    assert (obs === expVec)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expVec);
    end
  endtask

  task automatic checkCount(input string tag, input logic [3:0] obs, input logic [3:0] expVal);
    assertCount++;
    assert (obs === expVal)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expVal);
    end
  endtask

  // Directed sequence, one step per clock.
  initial begin
    reset = 1'b0;
    {ex_mem_read, ex_reg_write, id_uses_rs, id_uses_rt} = NOHZ;
    id_rs = 3'd0; id_rt = 3'd0; ex_rd = 3'd0;
    ex_branch_taken = 1'b0; id_halt = 1'b0; mem_wait = 1'b0; restart = 1'b0;
    #1;
    checkOutput("reset_t0", RSTV);
    @(negedge clock); #1;
    checkOutput("reset_c1", RSTV);
    @(negedge clock); #1;
    checkOutput("reset_c2", RSTV);
    @(negedge clock); reset = 1'b1; #1;
    checkOutput("run_default", RUNV);
    checkOutput1("run_default_f1", RUNV);

    $display("[TB] load-use detection");
    applyStimulus(LU, 3'd3, 3'd0, 3'd3, 0, 0, 0, 0);       checkOutput("lu_rs", STALLV);
    applyStimulus(NOHZ, 3'd3, 3'd0, 3'd3, 0, 0, 0, 0);     checkOutput("lu_clear", RUNV);
    applyStimulus(4'b1100, 3'd3, 3'd3, 3'd3, 0, 0, 0, 0);  checkOutput("lu_no_uses", RUNV);
    applyStimulus(4'b1101, 3'd6, 3'd3, 3'd3, 0, 0, 0, 0);  checkOutput("lu_rt", STALLV);
    applyStimulus(4'b1011, 3'd3, 3'd3, 3'd3, 0, 0, 0, 0);  checkOutput("lu_no_regwrite", RUNV);
    applyStimulus(4'b0111, 3'd3, 3'd3, 3'd3, 0, 0, 0, 0);  checkOutput("lu_no_load", RUNV);
    applyStimulus(LU, 3'd2, 3'd3, 3'd3, 0, 0, 0, 0);       checkOutput("lu_diff_reg", RUNV);

    $display("[TB] taken branch");
    applyStimulus(NOHZ, 0, 0, 0, 1, 0, 0, 0);  checkOutput("br_c0", BRV); checkOutput1("br_c0_f1", BRV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("br_c1", FLV); checkOutput1("br_c1_f1", RUNV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("br_c2", FLV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("br_done", RUNV);

    applyStimulus(NOHZ, 0, 0, 0, 1, 0, 0, 0);        checkOutput("rl_br0", BRV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);        checkOutput("rl_fl1", FLV);
    applyStimulus(NOHZ, 0, 0, 0, 1, 0, 0, 0);        checkOutput("rl_br_in_flush", BRV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);        checkOutput("rl_fl_a", FLV);
    applyStimulus(LU, 3'd3, 3'd0, 3'd3, 0, 0, 0, 0); checkOutput("rl_fl_b_lu_ignored", FLV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);        checkOutput("rl_done", RUNV);

    $display("[TB] mem_wait");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(LU, 3'd3, 3'd0, 3'd3, 0, 0, 1, 0);
      checkOutput($sformatf("mw_hold_%0d", i), HOLDV);
    end
    applyStimulus(LU, 3'd3, 3'd0, 3'd3, 0, 0, 0, 0);  checkOutput("mw_then_lu", STALLV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);         checkOutput("mw_lu_done", RUNV);

    applyStimulus(NOHZ, 0, 0, 0, 1, 0, 1, 0);  checkOutput("mw_br_masked", HOLDV);
    applyStimulus(NOHZ, 0, 0, 0, 1, 0, 0, 0);  checkOutput("mw_br_after", BRV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 1, 0);  checkOutput("mw_in_flush_a", HOLDV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 1, 0);  checkOutput("mw_in_flush_b", HOLDV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("mw_fl_resume1", FLV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("mw_fl_resume2", FLV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("mw_fl_done", RUNV);

    $display("[TB] halt");
    applyStimulus(NOHZ, 0, 0, 0, 0, 1, 0, 0);  checkOutput("hlt_entry", STALLV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("hlt_c1", HALTV); checkOutput1("hlt_c1_f1", HALTV);
    applyStimulus(NOHZ, 0, 0, 0, 1, 0, 0, 0);  checkOutput("hlt_br_ignored", HALTV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 1, 0);  checkOutput("hlt_mw", HHOLDV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 1);  checkOutput("hlt_restart", HALTV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("hlt_resumed", RUNV);

    applyStimulus(NOHZ, 0, 0, 0, 1, 1, 0, 0);  checkOutput("hltbr_c0", BRV); checkOutput1("hltbr_c0_f1", BRV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("hltbr_c1", FLV); checkOutput1("hltbr_c1_f1", RUNV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("hltbr_c2", FLV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("hltbr_done", RUNV);

    applyStimulus(LU, 3'd3, 3'd0, 3'd3, 0, 1, 0, 0);  checkOutput("hltlu_c0", STALLV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);         checkOutput("hltlu_c1", RUNV);

    $display("[TB] asynchronous reset mid-state");
    applyStimulus(NOHZ, 0, 0, 0, 0, 1, 0, 0);  checkOutput("rh_entry", STALLV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("rh_halted", HALTV);
    #2 reset = 1'b0; #1;
    checkOutput("rh_reset", RSTV);
    @(negedge clock); reset = 1'b1; #1;
    checkOutput("rh_released", RUNV);

    applyStimulus(NOHZ, 0, 0, 0, 1, 0, 0, 0);  checkOutput("rf_br", BRV);
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);  checkOutput("rf_flush", FLV);
    #2 reset = 1'b0; #1;
    checkOutput("rf_reset", RSTV);
    @(negedge clock); reset = 1'b1; #1;
    checkOutput("rf_released", RUNV);

`ifdef HAZARD_PERF_EN
    $display("[TB] performance counters");
    checkCount("perf_stall_reset", f1_stall_count, 4'd0);
    checkCount("perf_flush_reset", f1_flush_count, 4'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(LU, 3'd3, 3'd0, 3'd3, 0, 0, 0, 0);
      applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(NOHZ, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);
    end
    checkCount("perf_stall_3", f1_stall_count, 4'd3);
    checkCount("perf_flush_2", f1_flush_count, 4'd2);
    checkCount("perf_stall_3_dut", stall_count, 4'd3);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(LU, 3'd3, 3'd0, 3'd3, 0, 0, 0, 0);
    end
    applyStimulus(NOHZ, 0, 0, 0, 0, 0, 0, 0);
    checkCount("perf_stall_saturated", f1_stall_count, 4'd15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
